// File: rtl/div_if.sv
`default_nettype none
// ============================================================================
//  Module   : div_if
//  Brief    : Request/result bundle between the execute stage and the
//             multi-cycle divider.
//  Revision : 1.0 - initial release
// ============================================================================
interface div_if;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;

    // Execute stage side: issues requests, consumes the result.
    modport master (
        output start_i,
        output annul_i,
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        input  result_o,
        input  ready_o
    );

    // Divider side.
    modport slave (
        input  start_i,
        input  annul_i,
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        output result_o,
        output ready_o
    );
endinterface : div_if
`default_nettype wire

// File: rtl/div.sv
`default_nettype none
// ============================================================================
//  Module   : div
//  Brief    : 32-bit signed/unsigned restoring divider, one quotient bit per
//             cycle. result_o = {remainder, quotient}; divide-by-zero gives 0.
//  Revision : 1.0 - initial release
// ============================================================================
module div (
    input  wire   clk,
    input  wire   rst,
    div_if.slave  bus
);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    localparam logic [5:0] c_LAST_ITER = 6'd32;

    state_t      r_state,  w_state_next;
    logic [5:0]  r_cnt,    w_cnt_next;
    logic [31:0] r_rem,    w_rem_next;     // partial remainder
    logic [31:0] r_dvd,    w_dvd_next;     // dividend bits out at top, quotient bits in at bottom
    logic [31:0] r_dsr,    w_dsr_next;     // divisor magnitude
    logic        r_neg_q,  w_neg_q_next;   // quotient needs negation
    logic        r_neg_r,  w_neg_r_next;   // remainder needs negation
    logic [63:0] r_result, w_result_next;
    logic        r_ready,  w_ready_next;

    // Trial subtraction for one restoring step; bit 32 set means it went negative.
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    assign w_shift = {r_rem, r_dvd[31]};
    assign w_diff  = w_shift - {1'b0, r_dsr};

    // Operand magnitudes captured at the start-sampling edge.
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    assign w_abs1 = (bus.signed_div_i && bus.opdata1_i[31]) ? -bus.opdata1_i : bus.opdata1_i;
    assign w_abs2 = (bus.signed_div_i && bus.opdata2_i[31]) ? -bus.opdata2_i : bus.opdata2_i;

    // Sign-corrected final values (truncation toward zero).
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    assign w_quo_fix = r_neg_q ? -r_dvd : r_dvd;
    assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

    // State and datapath registers; reset returns everything to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FREE;
            r_cnt    <= 6'd0;
            r_rem    <= 32'd0;
            r_dvd    <= 32'd0;
            r_dsr    <= 32'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= 64'd0;
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_rem    <= w_rem_next;
            r_dvd    <= w_dvd_next;
            r_dsr    <= w_dsr_next;
            r_neg_q  <= w_neg_q_next;
            r_neg_r  <= w_neg_r_next;
            r_result <= w_result_next;
            r_ready  <= w_ready_next;
        end
    end

    // Next-state and datapath update for FREE/BYZERO/ON/END.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_rem_next    = r_rem;
        w_dvd_next    = r_dvd;
        w_dsr_next    = r_dsr;
        w_neg_q_next  = r_neg_q;
        w_neg_r_next  = r_neg_r;
        w_result_next = r_result;
        w_ready_next  = r_ready;

        case (r_state)
            S_FREE: begin
                w_result_next = 64'd0;
                w_ready_next  = 1'b0;
                // annul_i takes priority over a simultaneous start_i
                if (bus.start_i && !bus.annul_i) begin
                    w_cnt_next   = 6'd0;
                    w_rem_next   = 32'd0;
                    w_dvd_next   = w_abs1;
                    w_dsr_next   = w_abs2;
                    w_neg_q_next = bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                    w_neg_r_next = bus.signed_div_i & bus.opdata1_i[31];
                    w_state_next = (bus.opdata2_i == 32'd0) ? S_BYZERO : S_ON;
                end
            end

            S_BYZERO: begin
                w_result_next = 64'd0;
                if (bus.annul_i) begin
                    w_ready_next = 1'b0;
                    w_state_next = S_FREE;
                end else begin
                    w_ready_next = 1'b1;
                    w_state_next = S_END;
                end
            end

            S_ON: begin
                if (bus.annul_i) begin
                    w_result_next = 64'd0;
                    w_ready_next  = 1'b0;
                    w_state_next  = S_FREE;
                end else if (r_cnt == c_LAST_ITER) begin
                    w_result_next = {w_rem_fix, w_quo_fix};
                    w_ready_next  = 1'b1;
                    w_state_next  = S_END;
                end else begin
                    if (!w_diff[32]) begin
                        w_rem_next = w_diff[31:0];
                        w_dvd_next = {r_dvd[30:0], 1'b1};
                    end else begin
                        w_rem_next = w_shift[31:0];
                        w_dvd_next = {r_dvd[30:0], 1'b0};
                    end
                    w_cnt_next = r_cnt + 6'd1;
                end
            end

            S_END: begin
                // Result held while the request is still asserted.
                if (!bus.start_i) begin
                    w_result_next = 64'd0;
                    w_ready_next  = 1'b0;
                    w_state_next  = S_FREE;
                end
            end

            default: begin
                w_state_next = S_FREE;
            end
        endcase
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;

endmodule : div
`default_nettype wire

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL provide port clk, input, 1, rising-edge clock for all state.
REQ-002 The block SHALL provide port rst, input, 1, reset, synchronous, active-high.
REQ-003 The block SHALL provide port start_i, input, 1, division request from the execute stage, level-held until the result is consumed.
REQ-004 The block SHALL provide port annul_i, input, 1, cancel request (pipeline flush), sampled every cycle.
REQ-005 The block SHALL provide port signed_div_i, input, 1, 1 = signed (DIV), 0 = unsigned (DIVU).
REQ-006 The block SHALL provide port opdata1_i, input, 32, dividend.
REQ-007 The block SHALL provide port opdata2_i, input, 32, divisor.
REQ-008 The block SHALL provide port result_o, output, 64, {remainder[63:32], quotient[31:0]}, destined for HI/LO.
REQ-009 The block SHALL provide port ready_o, output, 1, result_o valid; the execute stage deasserts its stall request on it.

Function
REQ-010 The block SHALL implement four states: FREE, BYZERO, ON, END.
REQ-011 In FREE with start_i=1 and annul_i=0, the block SHALL latch operands, signedness and sign bits, clear the 6-bit iteration counter, and go to ON; a zero divisor SHALL go to BYZERO instead.
REQ-012 In FREE with start_i=0 or annul_i=1, the block SHALL remain in FREE with ready_o=0 and result_o=0.
REQ-013 For signed operation, latched operands SHALL be two's-complement absolute values; for unsigned, they SHALL be used as is.
REQ-014 In ON, each cycle SHALL perform one restoring-division step (shift partial remainder left, trial subtract divisor, set quotient bit on non-negative) and increment the counter.
REQ-015 When the counter reaches 32 in ON, the next edge SHALL apply sign correction, register result_o, set ready_o=1 and go to END.
REQ-016 Under sign correction, the quotient SHALL be negated when signed and the operand signs differ, and the remainder SHALL be negated when signed and the dividend is negative (truncation toward zero).
REQ-017 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0 (wraps, no exception).
REQ-018 BYZERO SHALL go to END on the next edge with result_o=0 and ready_o=1.
REQ-019 Latency SHALL be ready_o=1 after 34 edges counting the start-sampling edge as edge 1 (normal), or 2 edges (divide-by-zero).
REQ-020 END SHALL hold result_o and ready_o stable while start_i=1; on start_i=0, the next edge SHALL return to FREE with ready_o=0 and result_o=0.
REQ-021 In ON or BYZERO, annul_i=1 SHALL force FREE on the next edge, ready_o=0, and discard the partial result.
REQ-022 Operand or signedness changes after the start-sampling edge SHALL NOT affect the result.
REQ-023 start_i SHALL be ignored in ON, BYZERO and END; a new division SHALL require a pass through FREE (minimum 1 idle cycle between results).
REQ-024 When annul_i and start_i are both asserted in FREE, annul_i SHALL win and no division SHALL start.

Reset
REQ-025 rst=1 at a rising edge SHALL force FREE, counter=0, result_o=0 and ready_o=0, in any state including mid-division.
REQ-026 After rst deasserts, the block SHALL accept start_i on the first edge with no residual state.

Verification
REQ-027 Unsigned 100/7, start held -> ready_o at edge 34, result_o={0x00000002,0x0000000E}; start_i dropped -> FREE, ready_o=0 next edge.
REQ-028 Signed -7/2 (0xFFFFFFF9/0x00000002) -> result_o={0xFFFFFFFF,0xFFFFFFFD}; signed 7/-2 -> {0x00000001,0xFFFFFFFD}.
REQ-029 Divisor 0 (either mode) -> BYZERO then END, ready_o=1 at edge 2, result_o=0.
REQ-030 annul_i pulsed at iteration 10 -> FREE next edge, ready_o never asserts; new start 0xFFFFFFFF/1 unsigned -> {0,0xFFFFFFFF}.
REQ-031 Signed 0x80000000/0xFFFFFFFF -> {0x00000000,0x80000000}; operands changed mid-division -> result unchanged.
REQ-032 rst asserted at iteration 20 -> FREE, outputs 0 next edge; following start 9/3 completes normally with {0,3}.
